// File: rtl/run_length_logger.sv
`default_nettype none
// ============================================================================
// Module      : run_length_logger
// Description : Turns each maximal match interval of a four-in-a-row detector
//               into a {pol, len} run record. Records are queued in a small
//               circular FIFO that a reader drains with a valid/ready
//               handshake. Per-polarity counters of completed runs are kept.
//
// Ports       : clk       - sole clock, rising edge
//               reset     - synchronous, active-high
//               z         - detector match output
//               zpol      - run type while z=1 (1 = ones, 0 = zeros)
//               rd_ready  - reader accepts the head record this cycle
//               rd_valid  - FIFO non-empty, rd_data is valid
//               rd_data   - head record {pol, len}, pol in the MSB
//               ones_cnt  - completed ones-runs (pushed or dropped), saturating
//               zeros_cnt - completed zeros-runs (pushed or dropped), saturating
//               overflow  - sticky, a record was dropped on a full FIFO
//               busy      - a run is currently being measured
//
// Revision    : 1.0 - initial release
// ============================================================================
module run_length_logger #(
    parameter int LEN_W = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             z,
    input  logic             zpol,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [LEN_W:0]   rd_data,
    output logic [CNT_W-1:0] ones_cnt,
    output logic [CNT_W-1:0] zeros_cnt,
    output logic             overflow,
    output logic             busy
);

    localparam int               c_ptr_w    = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_depth    = DEPTH[c_ptr_w:0];
    // The first match cycle already stands for four equal samples.
    localparam logic [LEN_W-1:0] c_len_init = LEN_W'(4);
    localparam logic [LEN_W-1:0] c_len_max  = '1;
    localparam logic [CNT_W-1:0] c_cnt_max  = '1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               pol_q, pol_d;
    logic [LEN_W:0]     mem_q [DEPTH];
    logic [LEN_W:0]     mem_d [DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_ptr_w:0]   count_q, count_d;
    logic [CNT_W-1:0]   ones_cnt_q, ones_cnt_d;
    logic [CNT_W-1:0]   zeros_cnt_q, zeros_cnt_d;
    logic               overflow_q, overflow_d;

    logic               emit;
    logic [LEN_W:0]     rec;
    logic               pop;
    logic               full;
    logic               push;
    logic               drop;

    // ------------------------------------------------------------------
    // Run measurement FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        pol_d   = pol_q;
        emit    = 1'b0;
        rec     = {pol_q, len_q};
        case (state_q)
            ST_IDLE: begin
                if (z) begin
                    state_d = ST_RUN;
                    len_d   = c_len_init;
                    pol_d   = zpol;
                end
            end
            ST_RUN: begin
                if (!z) begin
                    emit    = 1'b1;
                    state_d = ST_IDLE;
                end else if (zpol != pol_q) begin
                    // Polarity flip without a gap: close this run and start
                    // a fresh one in the same cycle.
                    emit  = 1'b1;
                    len_d = c_len_init;
                    pol_d = zpol;
                end else if (len_q != c_len_max) begin
                    len_d = len_q + LEN_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Record FIFO and counters
    // ------------------------------------------------------------------
    always_comb begin
        pop  = (count_q != '0) && rd_ready;
        full = (count_q == c_depth);
        // A pop in the same cycle frees the slot the push needs.
        push = emit && (!full || pop);
        drop = emit && full && !pop;

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = rec;
        end

        wr_ptr_d = push ? (wr_ptr_q + c_ptr_w'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + c_ptr_w'(1)) : rd_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + (c_ptr_w + 1)'(1);
            2'b01:   count_d = count_q - (c_ptr_w + 1)'(1);
            default: count_d = count_q;
        endcase

        ones_cnt_d  = ones_cnt_q;
        zeros_cnt_d = zeros_cnt_q;
        if (emit) begin
            if (rec[LEN_W]) begin
                if (ones_cnt_q != c_cnt_max) ones_cnt_d = ones_cnt_q + CNT_W'(1);
            end else begin
                if (zeros_cnt_q != c_cnt_max) zeros_cnt_d = zeros_cnt_q + CNT_W'(1);
            end
        end

        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            pol_q       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ones_cnt_q  <= '0;
            zeros_cnt_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            pol_q       <= pol_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ones_cnt_q  <= ones_cnt_d;
            zeros_cnt_q <= zeros_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    assign rd_valid  = (count_q != '0);
    assign rd_data   = mem_q[rd_ptr_q];
    assign ones_cnt  = ones_cnt_q;
    assign zeros_cnt = zeros_cnt_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q == ST_RUN);

endmodule
`default_nettype wire
